// File: rtl/wb_rr_interconnect.sv
// N-master round-robin Wishbone interconnect in front of the shared L2 slave port.
// Holds the grant for a whole transaction, routes ACK/RTY to the owner only, and turns hung cycles into a retry.
module wb_rr_interconnect #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int SEL_WIDTH  = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             m_cyc,
    input  logic [NUM_PORTS-1:0]             m_stb,
    input  logic [NUM_PORTS-1:0]             m_we,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0]   m_sel,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  m_adr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  m_datm,
    output logic [DATA_WIDTH-1:0]            m_dats,
    output logic [NUM_PORTS-1:0]             m_ack,
    output logic [NUM_PORTS-1:0]             m_rty,
    output logic                             s_cyc,
    output logic                             s_stb,
    output logic                             s_we,
    output logic [SEL_WIDTH-1:0]             s_sel,
    output logic [ADDR_WIDTH-1:0]            s_adr,
    output logic [DATA_WIDTH-1:0]            s_datm,
    input  logic [DATA_WIDTH-1:0]            s_dats,
    input  logic                             s_ack,
    input  logic                             s_rty,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             timeout_err
);

    localparam int PW      = $clog2(NUM_PORTS);
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                r_state, w_state_next;
    logic [NUM_PORTS-1:0]  r_grant, w_grant_next;
    logic [PW-1:0]         r_owner, w_owner_next;
    logic [PW-1:0]         r_ptr, w_ptr_next;
    logic [CW-1:0]         r_count, w_count_next;

    logic [NUM_PORTS-1:0]  w_req;
    logic [PW-1:0]         w_idx;
    logic [PW-1:0]         w_pick;
    logic                  w_found;
    logic                  w_fire;
    logic                  w_exit;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NUM_PORTS - 1)) ? '0 : v + PW'(1);
    endfunction

    assign w_req = m_cyc & m_stb;

    // Scan from the rotating pointer upward; the first requester found wins.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path can infer a latch.
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = r_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
            w_idx = wrap_inc(w_idx);
        end
    end

    // The watchdog yields to a real response arriving in its last cycle.
    assign w_fire = (TIMEOUT > 0) && (r_state == ST_BUSY) && (r_count == CW'(TO_LAST))
                    && !s_ack && !s_rty;
    assign w_exit = s_ack || s_rty || !m_cyc[r_owner] || w_fire;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next         = ST_BUSY;
                    w_grant_next         = '0;
                    w_grant_next[w_pick] = 1'b1;
                    w_owner_next         = w_pick;
                    w_count_next         = '0;
                end
            end
            ST_BUSY: begin
                if (w_exit) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = wrap_inc(r_owner);
                end else begin
                    w_count_next = r_count + CW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_count <= w_count_next;
        end
    end

    // Slave side is an AND-OR mux on the one-hot grant, so it is all zero while idle.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_sel  = '0;
        s_adr  = '0;
        s_datm = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                s_cyc  = m_cyc[i];
                s_stb  = m_stb[i];
                s_we   = m_we[i];
                s_sel  = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
                s_adr  = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_datm = m_datm[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign m_dats      = s_dats;
    assign m_ack       = r_grant & {NUM_PORTS{s_ack}};
    assign m_rty       = r_grant & {NUM_PORTS{s_rty | w_fire}};
    assign grant       = r_grant;
    assign timeout_err = w_fire;

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Bench for wb_rr_interconnect (3 ports, watchdog of 4): a cycle-level scoreboard model
// plus directed scenarios with hand-computed expectations.
module tb_wb_rr_interconnect;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_datm;
    logic [DW-1:0]   m_dats;
    logic [N-1:0]    m_ack, m_rty;
    logic            s_cyc, s_stb, s_we;
    logic [SW-1:0]   s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_datm;
    logic [DW-1:0]   s_dats;
    logic            s_ack = 1'b0;
    logic            s_rty = 1'b0;
    logic [N-1:0]    grant;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    wb_rr_interconnect #(
        .NUM_PORTS (N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .SEL_WIDTH (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_cyc      (m_cyc),
        .m_stb      (m_stb),
        .m_we       (m_we),
        .m_sel      (m_sel),
        .m_adr      (m_adr),
        .m_datm     (m_datm),
        .m_dats     (m_dats),
        .m_ack      (m_ack),
        .m_rty      (m_rty),
        .s_cyc      (s_cyc),
        .s_stb      (s_stb),
        .s_we       (s_we),
        .s_sel      (s_sel),
        .s_adr      (s_adr),
        .s_datm     (s_datm),
        .s_dats     (s_dats),
        .s_ack      (s_ack),
        .s_rty      (s_rty),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; literal checks happen 3 units after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // L2 responder: acks (or retries) on the l2_delay-th cycle of a transaction; 0 never answers.
    int   l2_delay  = 0;
    logic l2_rty    = 1'b0;
    logic l2_stray  = 1'b0;
    int   busy_cnt  = 0;

    always @(posedge clk) begin
        #2;
        if (s_cyc && s_stb) busy_cnt++;
        else busy_cnt = 0;
        s_ack = l2_stray || (!l2_rty && l2_delay > 0 && busy_cnt == l2_delay);
        s_rty = l2_rty && l2_delay > 0 && busy_cnt == l2_delay;
    end

    // Behavioural model: owner index (-1 idle), next-search start, BUSY cycle number.
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_count = 0;

    always @(negedge clk) begin : scoreboard
        logic [N-1:0]  e_grant, e_ack, e_rty;
        logic [2:0]    e_ctl;
        logic [SW-1:0] e_sel;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_datm;
        logic          e_err, fire;
        int            o, p;
        e_grant = '0; e_ack = '0; e_rty = '0; e_ctl = '0;
        e_sel = '0; e_adr = '0; e_datm = '0; e_err = 1'b0; fire = 1'b0;
        o = mdl_owner;
        if (!rst && o >= 0) begin
            fire       = (mdl_count == TO - 1) && !s_ack && !s_rty;
            e_grant[o] = 1'b1;
            e_ctl      = {m_cyc[o], m_stb[o], m_we[o]};
            e_sel      = m_sel[o*SW +: SW];
            e_adr      = m_adr[o*AW +: AW];
            e_datm     = m_datm[o*DW +: DW];
            e_ack[o]   = s_ack;
            e_rty[o]   = s_rty || fire;
            e_err      = fire;
        end
        check("sb grant", grant, e_grant);
        check("sb s_cyc/stb/we", {s_cyc, s_stb, s_we}, e_ctl);
        check("sb s_sel", s_sel, e_sel);
        check("sb s_adr", s_adr, e_adr);
        check("sb s_datm", s_datm, e_datm);
        check("sb m_ack", m_ack, e_ack);
        check("sb m_rty", m_rty, e_rty);
        check("sb timeout_err", timeout_err, e_err);
        check("sb m_dats", m_dats, s_dats);

        if (rst) begin
            mdl_owner = -1;
            mdl_ptr   = 0;
            mdl_count = 0;
        end else if (o < 0) begin
            for (int k = 0; k < N; k++) begin
                p = (mdl_ptr + k) % N;
                if (mdl_owner < 0 && m_cyc[p] && m_stb[p]) begin
                    mdl_owner = p;
                    mdl_count = 0;
                end
            end
        end else if (s_ack || s_rty || !m_cyc[o] || fire) begin
            mdl_owner = -1;
            mdl_ptr   = (o + 1) % N;
        end else begin
            mdl_count++;
        end
    end

    // Grant-start recorder for ordering scenarios.
    typedef struct {
        int           cyc;
        logic [N-1:0] g;
    } grant_ev_t;

    grant_ev_t    q_ev[$];
    logic [N-1:0] exp_order [6];

    task automatic record(input int ncyc);
        logic [N-1:0] prev;
        prev = '0;
        q_ev.delete();
        for (int c = 0; c < ncyc; c++) begin
            step();
            settle();
            if (grant != '0 && prev == '0) q_ev.push_back('{c, grant});
            prev = grant;
        end
    endtask

    task automatic check_order(input string name, input int n);
        check({name, " grant count"}, q_ev.size(), n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s grant #%0d", name, k), (k < q_ev.size()) ? q_ev[k].g : '0, exp_order[k]);
        check({name, " dead-cycle gap"}, (q_ev.size() > 1) ? q_ev[1].cyc - q_ev[0].cyc : 0, 3);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drop_all();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        m_cyc  = '0;
        m_stb  = '0;
        m_we   = '0;
        m_adr  = {12'h222, 12'h0A5, 12'h111};
        m_sel  = {4'hC, 4'h3, 4'hF};
        m_datm = {32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        s_dats = 32'hCAFE_0000;

        // Reset state
        step(); settle();
        check("reset grant", grant, 3'b000);
        check("reset s_cyc", s_cyc, 1'b0);
        check("reset m_ack", m_ack, 3'b000);
        check("reset timeout_err", timeout_err, 1'b0);
        s_dats = 32'h1234_ABCD;
        #1;
        check("reset m_dats follows s_dats", m_dats, 32'h1234_ABCD);
        step();
        rst = 1'b0;
        step();

        // Single master: port 1 reads 0x0A5, L2 acks in the 3rd BUSY cycle
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; l2_delay = 3; s_dats = 32'h1234_5678;
        settle();
        check("single t0 grant", grant, 3'b000);
        step(); settle();
        check("single t1 grant", grant, 3'b010);
        check("single t1 s_cyc", s_cyc, 1'b1);
        check("single t1 s_adr", s_adr, 12'h0A5);
        step(); settle();
        check("single t2 m_ack", m_ack, 3'b000);
        step(); settle();
        check("single t3 m_ack", m_ack, 3'b010);
        check("single t3 m_dats", m_dats, 32'h1234_5678);
        step();
        drop_all();
        settle();
        check("single t4 grant", grant, 3'b000);
        check("single t4 s_cyc", s_cyc, 1'b0);

        // Simultaneous ports 0 and 1 from reset: alternation 0,1,0,1
        reset_dut();
        m_cyc = 3'b011; m_stb = 3'b011; l2_delay = 2;
        record(12);
        exp_order = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000};
        check_order("alternate", 4);
        drop_all();

        // Fairness: all three request continuously
        reset_dut();
        m_cyc = 3'b111; m_stb = 3'b111; l2_delay = 2;
        record(18);
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        check_order("fair", 6);
        drop_all();

        // Watchdog: port 1 never answered, retry in 4th BUSY cycle
        reset_dut();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; l2_delay = 0;
        step(); settle();
        check("wdog t1 grant", grant, 3'b010);
        check("wdog t1 timeout_err", timeout_err, 1'b0);
        for (int c = 2; c <= 3; c++) begin
            step(); settle();
            check($sformatf("wdog t%0d timeout_err", c), timeout_err, 1'b0);
        end
        step(); settle();
        check("wdog t4 m_rty", m_rty, 3'b010);
        check("wdog t4 timeout_err", timeout_err, 1'b1);
        check("wdog t4 m_ack", m_ack, 3'b000);
        step();
        m_cyc = 3'b101; m_stb = 3'b101; l2_delay = 2;
        settle();
        check("wdog t5 s_cyc", s_cyc, 1'b0);
        check("wdog t5 grant", grant, 3'b000);
        step(); settle();
        check("wdog ptr advanced grant", grant, 3'b100);
        step();
        step();
        drop_all();
        settle();
        check("wdog after grant", grant, 3'b000);

        // Abort: owner drops CYC mid-transaction
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; l2_delay = 0;
        step(); settle();
        check("abort t1 grant", grant, 3'b001);
        step();
        drop_all();
        settle();
        check("abort t2 s_cyc", s_cyc, 1'b0);
        check("abort t2 grant held", grant, 3'b001);
        step(); settle();
        check("abort t3 grant", grant, 3'b000);

        // Retry on a write from port 2
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; l2_delay = 2; l2_rty = 1'b1;
        step(); settle();
        check("retry t1 grant", grant, 3'b100);
        check("retry t1 s_we", s_we, 1'b1);
        step(); settle();
        check("retry t2 m_rty", m_rty, 3'b100);
        check("retry t2 m_ack", m_ack, 3'b000);
        check("retry t2 timeout_err", timeout_err, 1'b0);
        step();
        drop_all();
        l2_rty = 1'b0;
        settle();
        check("retry t3 grant", grant, 3'b000);

        // Stray ACK while idle is dropped
        step();
        l2_stray = 1'b1;
        settle();
        check("stray m_ack", m_ack, 3'b000);
        check("stray m_rty", m_rty, 3'b000);
        l2_stray = 1'b0;

        // ACK coinciding with the watchdog's last cycle: ACK wins
        step();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; l2_delay = 4;
        for (int c = 1; c <= 3; c++) step();
        step(); settle();
        check("ack-vs-wdog m_ack", m_ack, 3'b001);
        check("ack-vs-wdog m_rty", m_rty, 3'b000);
        check("ack-vs-wdog timeout_err", timeout_err, 1'b0);
        step();
        drop_all();
        settle();
        check("ack-vs-wdog release", grant, 3'b000);

        // Reset mid-transaction (pointer was left at 1 by the port-0 transaction)
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; l2_delay = 0;
        step(); settle();
        check("midrst t1 grant", grant, 3'b010);
        step();
        rst = 1'b1; l2_stray = 1'b1; m_cyc = 3'b011; m_stb = 3'b011;
        settle();
        check("midrst s_cyc", s_cyc, 1'b0);
        check("midrst grant", grant, 3'b000);
        check("midrst m_ack", m_ack, 3'b000);
        l2_stray = 1'b0;
        step();
        rst = 1'b0; l2_delay = 2;
        step(); settle();
        check("midrst tie to port 0", grant, 3'b001);
        step();
        step();
        drop_all();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
